// File: rtl/sweep_sequencer_if.sv
// Configuration and update-handshake bundle between the sweep sequencer and its
// configuration source / DDS datapath.
interface sweep_sequencer_if;
  logic [1:0]  sweep_mode;
  logic [19:0] center_freq;
  logic [16:0] sweep_range;
  logic [12:0] sweep_speed;
  logic [19:0] freq_inst;
  logic        upd_valid;
  logic        upd_ready;
  logic        sweep_active;
  logic        sweep_wrap;

  modport master (
    output sweep_mode, center_freq, sweep_range, sweep_speed, upd_ready,
    input  freq_inst, upd_valid, sweep_active, sweep_wrap
  );

  modport slave (
    input  sweep_mode, center_freq, sweep_range, sweep_speed, upd_ready,
    output freq_inst, upd_valid, sweep_active, sweep_wrap
  );
endinterface

// File: rtl/sweep_sequencer.sv
// Steps the waveform generator frequency once per sweep tick (ramp up, ramp down
// or triangle) and offers every new value to the datapath over valid/ready.
module sweep_sequencer #(
  parameter int TICK_CYCLES = 100000,
  parameter int F_MIN       = 1000,
  parameter int F_MAX       = 999999
) (
  input logic              clk,
  input logic              rst_n,
  sweep_sequencer_if.slave bus
);

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN_UP, RUN_DOWN} sweepState_t;

  sweepState_t   r_state, w_stateNext;
  logic [TW-1:0] r_tick;
  logic [1:0]    r_mode, r_modePrev;
  logic [19:0]   r_freq, r_fLo, r_fHi;
  logic [19:0]   w_freqNext, w_fLoNext, w_fHiNext;
  logic [12:0]   r_spd, w_spdNext;
  logic          r_valid, r_active, r_wrap;
  logic          w_wrapNext, w_latch, w_tick, w_restart, w_hold;
  logic [20:0]   w_center, w_half, w_sum, w_upSum, w_downFloor;
  logic [19:0]   w_bandLo, w_bandHi, w_centerClamp;

  assign w_tick    = (r_tick == TW'(TICK_CYCLES - 1));
  assign w_restart = (r_mode != r_modePrev);
  assign w_hold    = (r_spd == 13'd0) || (r_fLo == r_fHi);

  // Band limits from the live configuration; only sampled when w_latch is set.
  assign w_center = {1'b0, bus.center_freq};
  assign w_half   = 21'(bus.sweep_range >> 1);
  assign w_sum    = w_center + w_half;
  assign w_bandHi = (w_sum > 21'(F_MAX)) ? 20'(F_MAX) : w_sum[19:0];
  assign w_bandLo = (w_center >= w_half + 21'(F_MIN)) ? 20'(w_center - w_half) : 20'(F_MIN);

  assign w_centerClamp = (bus.center_freq < 20'(F_MIN)) ? 20'(F_MIN) :
                         (bus.center_freq > 20'(F_MAX)) ? 20'(F_MAX) : bus.center_freq;

  assign w_upSum     = {1'b0, r_freq} + 21'(r_spd);
  assign w_downFloor = {1'b0, r_fLo} + 21'(r_spd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick <= '0;
    end else begin
      r_tick <= w_tick ? '0 : r_tick + 1'b1;
    end
  end

  // Restart beats a tick in the same cycle; degenerate bands simply hold.
  always_comb begin
    w_stateNext = r_state;
    w_freqNext  = r_freq;
    w_wrapNext  = 1'b0;
    w_latch     = 1'b0;
    if (w_restart) begin
      case (r_mode)
        2'b00: begin
          w_stateNext = IDLE;
          w_freqNext  = w_centerClamp;
        end
        2'b10: begin
          w_latch     = 1'b1;
          w_freqNext  = w_bandHi;
          w_stateNext = RUN_DOWN;
        end
        default: begin
          w_latch     = 1'b1;
          w_freqNext  = w_bandLo;
          w_stateNext = RUN_UP;
        end
      endcase
    end else begin
      case (r_state)
        IDLE: w_freqNext = w_centerClamp;
        RUN_UP: begin
          if (w_tick && !w_hold) begin
            if (w_upSum < {1'b0, r_fHi}) begin
              w_freqNext = w_upSum[19:0];
            end else if (r_mode == 2'b11) begin
              w_freqNext  = r_fHi;
              w_stateNext = RUN_DOWN;
            end else begin
              w_latch    = 1'b1;
              w_freqNext = w_bandLo;
              w_wrapNext = 1'b1;
            end
          end
        end
        RUN_DOWN: begin
          if (w_tick && !w_hold) begin
            if ({1'b0, r_freq} > w_downFloor) begin
              w_freqNext = r_freq - 20'(r_spd);
            end else if (r_mode == 2'b10) begin
              w_latch    = 1'b1;
              w_freqNext = w_bandHi;
              w_wrapNext = 1'b1;
            end else begin
              w_latch     = 1'b1;
              w_freqNext  = w_bandLo;
              w_wrapNext  = 1'b1;
              w_stateNext = RUN_UP;
            end
          end
        end
        default: w_stateNext = IDLE;
      endcase
    end
  end

  assign w_fLoNext = w_latch ? w_bandLo : r_fLo;
  assign w_fHiNext = w_latch ? w_bandHi : r_fHi;
  assign w_spdNext = w_latch ? bus.sweep_speed : r_spd;

  // A fresh value re-arms valid even in the cycle the old one is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_freq     <= 20'(F_MIN);
      r_fLo      <= 20'(F_MIN);
      r_fHi      <= 20'(F_MIN);
      r_spd      <= '0;
      r_valid    <= 1'b1;
      r_active   <= 1'b0;
      r_wrap     <= 1'b0;
      r_mode     <= 2'b00;
      r_modePrev <= 2'b00;
    end else begin
      r_state    <= w_stateNext;
      r_freq     <= w_freqNext;
      r_fLo      <= w_fLoNext;
      r_fHi      <= w_fHiNext;
      r_spd      <= w_spdNext;
      r_active   <= (r_state != IDLE);
      r_wrap     <= w_wrapNext;
      r_mode     <= bus.sweep_mode;
      r_modePrev <= r_mode;
      if (w_freqNext != r_freq) begin
        r_valid <= 1'b1;
      end else if (r_valid && bus.upd_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.freq_inst    = r_freq;
  assign bus.upd_valid    = r_valid;
  assign bus.sweep_active = r_active;
  assign bus.sweep_wrap   = r_wrap;

endmodule

// File: tb/tb_sweep_sequencer.sv
// Randomized bench for sweep_sequencer: a behavioural sweep model predicts every
// output each cycle, plus directed checks on the classic ramp and clamp cases.
module tb_sweep_sequencer;

  localparam int TICKS = 10;
  localparam int FMIN  = 1000;
  localparam int FMAX  = 999999;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  sweep_sequencer_if bus();

  sweep_sequencer #(.TICK_CYCLES(TICKS), .F_MIN(FMIN), .F_MAX(FMAX)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: phase 0 idle, 1 rising, 2 falling.
  int mModeNow, mModeOld, mTick, mPhase, mFreq, mLo, mHi, mSpd;
  bit mValid, mActive, mWrap;

  bit capOn = 1'b0;
  int lastFreq;
  int capQ[$];

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int clampF(input int f);
    if (f < FMIN) return FMIN;
    if (f > FMAX) return FMAX;
    return f;
  endfunction

  task automatic modelBand();
    int c, half;
    c    = int'(bus.center_freq);
    half = int'(bus.sweep_range) / 2;
    mLo  = (c - half < FMIN) ? FMIN : c - half;
    mHi  = (c + half > FMAX) ? FMAX : c + half;
    mSpd = int'(bus.sweep_speed);
  endtask

  task automatic modelReset();
    mModeNow = 0; mModeOld = 0; mTick = 0; mPhase = 0;
    mFreq = FMIN; mLo = FMIN; mHi = FMIN; mSpd = 0;
    mValid = 1'b1; mActive = 1'b0; mWrap = 1'b0;
  endtask

  task automatic modelStep();
    int nf, oldPhase;
    bit restart, tick;
    restart  = (mModeNow != mModeOld);
    tick     = (mTick == TICKS - 1);
    oldPhase = mPhase;
    nf       = mFreq;
    mWrap    = 1'b0;
    if (restart) begin
      if (mModeNow == 0) begin
        mPhase = 0; nf = clampF(int'(bus.center_freq));
      end else if (mModeNow == 2) begin
        modelBand(); nf = mHi; mPhase = 2;
      end else begin
        modelBand(); nf = mLo; mPhase = 1;
      end
    end else if (mPhase == 0) begin
      nf = clampF(int'(bus.center_freq));
    end else if (tick && mSpd != 0 && mLo != mHi) begin
      if (mPhase == 1) begin
        if (mFreq + mSpd < mHi) nf = mFreq + mSpd;
        else if (mModeNow == 3) begin nf = mHi; mPhase = 2; end
        else begin modelBand(); nf = mLo; mWrap = 1'b1; end
      end else begin
        if (mFreq > mLo + mSpd) nf = mFreq - mSpd;
        else if (mModeNow == 2) begin modelBand(); nf = mHi; mWrap = 1'b1; end
        else begin modelBand(); nf = mLo; mWrap = 1'b1; mPhase = 1; end
      end
    end
    if (nf != mFreq) mValid = 1'b1;
    else if (mValid && bus.upd_ready) mValid = 1'b0;
    mFreq    = nf;
    mActive  = (oldPhase != 0);
    mModeOld = mModeNow;
    mModeNow = int'(bus.sweep_mode);
    mTick    = (mTick + 1) % TICKS;
  endtask

  task automatic compareAll();
    checkOutput("freq_inst", int'(bus.freq_inst), mFreq);
    checkOutput("upd_valid", int'(bus.upd_valid), int'(mValid));
    checkOutput("sweep_active", int'(bus.sweep_active), int'(mActive));
    checkOutput("sweep_wrap", int'(bus.sweep_wrap), int'(mWrap));
    checkOutput("freq_in_range",
                int'(bus.freq_inst >= 20'(FMIN) && bus.freq_inst <= 20'(FMAX)), 1);
  endtask

  task automatic randomizeInputs();
    if ($urandom_range(0, 79) == 0) bus.sweep_mode = 2'($urandom_range(0, 3));
    if ($urandom_range(0, 29) == 0) begin
      case ($urandom_range(0, 3))
        0: bus.center_freq = 20'($urandom_range(FMIN, FMIN + 30000));
        1: bus.center_freq = 20'($urandom_range(FMAX - 30000, FMAX));
        default: bus.center_freq = 20'($urandom_range(FMIN, FMAX));
      endcase
      bus.sweep_range = ($urandom_range(0, 7) == 0) ? 17'd0 : 17'($urandom_range(0, 50000));
      bus.sweep_speed = ($urandom_range(0, 7) == 0) ? 13'd0 : 13'($urandom_range(1, 4000));
    end
    bus.upd_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic applyStimulus(input int nCycles, input bit randomize);
    for (int i = 0; i < nCycles; i++) begin
      @(posedge clk);
      modelStep();
      #1;
      compareAll();
      if (capOn && int'(bus.freq_inst) != lastFreq) begin
        capQ.push_back(int'(bus.freq_inst));
        lastFreq = int'(bus.freq_inst);
      end
      if (randomize) randomizeInputs();
    end
  endtask

  initial begin
    int expSeq[7] = '{90000, 94000, 98000, 102000, 106000, 90000, 94000};

    bus.sweep_mode  = 2'b00;
    bus.center_freq = 20'd100000;
    bus.sweep_range = 17'd0;
    bus.sweep_speed = 13'd0;
    bus.upd_ready   = 1'b1;
    modelReset();

    #12;
    checkOutput("rst_freq", int'(bus.freq_inst), FMIN);
    checkOutput("rst_valid", int'(bus.upd_valid), 1);
    checkOutput("rst_active", int'(bus.sweep_active), 0);
    checkOutput("rst_wrap", int'(bus.sweep_wrap), 0);
    #10 rst_n = 1'b1;

    // Sweep off: centre passes through.
    applyStimulus(6, 1'b0);
    checkOutput("idle_freq", int'(bus.freq_inst), 100000);

    // Sawtooth up with the reference settings.
    bus.sweep_range = 17'd20000;
    bus.sweep_speed = 13'd4000;
    lastFreq = int'(bus.freq_inst);
    capOn = 1'b1;
    bus.sweep_mode = 2'b01;
    applyStimulus(70, 1'b0);
    capOn = 1'b0;
    checkOutput("ramp_seq_len", int'(capQ.size() >= 7), 1);
    for (int k = 0; k < 7; k++) begin
      if (k < capQ.size()) checkOutput($sformatf("ramp_seq%0d", k), capQ[k], expSeq[k]);
    end

    // Triangle.
    bus.sweep_mode = 2'b11;
    applyStimulus(150, 1'b0);

    // Band clamps at both ends.
    bus.center_freq = 20'd2000;
    bus.sweep_range = 17'd50000;
    bus.sweep_mode  = 2'b01;
    applyStimulus(60, 1'b0);
    bus.center_freq = 20'd990000;
    bus.sweep_mode  = 2'b10;
    applyStimulus(2, 1'b0);
    checkOutput("fmax_start", int'(bus.freq_inst), FMAX);
    applyStimulus(58, 1'b0);

    // Datapath back-pressure: latest value wins, sweep keeps going.
    bus.center_freq = 20'd100000;
    bus.sweep_range = 17'd20000;
    bus.sweep_mode  = 2'b01;
    applyStimulus(15, 1'b0);
    bus.upd_ready = 1'b0;
    applyStimulus(35, 1'b0);
    checkOutput("valid_held", int'(bus.upd_valid), 1);
    bus.upd_ready = 1'b1;
    applyStimulus(5, 1'b0);

    // Range change mid-segment only lands at the next wrap.
    applyStimulus(12, 1'b0);
    bus.sweep_range = 17'd0;
    applyStimulus(70, 1'b0);
    bus.sweep_range = 17'd20000;
    bus.sweep_mode  = 2'b10;
    applyStimulus(2, 1'b0);
    checkOutput("down_start", int'(bus.freq_inst), 110000);
    applyStimulus(8, 1'b0);

    // Asynchronous reset between clock edges.
    #3 rst_n = 1'b0;
    #1;
    checkOutput("arst_freq", int'(bus.freq_inst), FMIN);
    checkOutput("arst_valid", int'(bus.upd_valid), 1);
    checkOutput("arst_active", int'(bus.sweep_active), 0);
    checkOutput("arst_wrap", int'(bus.sweep_wrap), 0);
    modelReset();
    #3 rst_n = 1'b1;
    applyStimulus(40, 1'b0);

    // Randomized soak.
    applyStimulus(4000, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sweep_sequencer.md
Name: sweep_sequencer

Overview:
- Sequences the waveform generator's output frequency during a sweep. It takes the user configuration (centre frequency, sweep range, sweep speed, sweep mode) and produces the instantaneous frequency for the DDS/phase-accumulator datapath.
- The value advances once per 1 ms tick.
- Each new frequency is delivered to the datapath over a valid/ready update handshake.
- When the sweep is off, the centre frequency passes straight through.

Parameters:
TICK_CYCLES, 100000, clk cycles per 1 ms sweep tick (100 MHz clk); benches override to a small value
F_MIN, 1000, lowest legal output frequency in Hz
F_MAX, 999999, highest legal output frequency in Hz

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous, active-low reset
sweep_mode  input  2  00 off, 01 ramp up (sawtooth), 10 ramp down (sawtooth), 11 triangle
center_freq  input  20  configured frequency in Hz (F_MIN..F_MAX)
sweep_range  input  17  total sweep span in Hz (0..50000)
sweep_speed  input  13  step per tick in Hz (0..4000)
freq_inst  output  20  current frequency to datapath, Hz
upd_valid  output  1  freq_inst holds a value not yet accepted by datapath
upd_ready  input  1  datapath accepts freq_inst when upd_valid&&upd_ready
sweep_active  output  1  high in RUN_UP/RUN_DOWN
sweep_wrap  output  1  one-cycle pulse at each sawtooth wrap or triangle low turnaround

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. Reset values: state IDLE, tick counter 0, freq_inst=F_MIN, upd_valid=1 (forces initial load), sweep_active=0, sweep_wrap=0.
- Tick: free-running counter 0..TICK_CYCLES-1; the tick strobe is high for one cycle when the counter reaches TICK_CYCLES-1. The counter never resets except on rst_n.
- Band latch, in 21-bit arithmetic:
  - half = sweep_range>>1 (floor).
  - f_lo = max(center_freq-half, F_MIN), with no underflow.
  - f_hi = min(center_freq+half, F_MAX).
  - spd = sweep_speed.
  - Latched on entry to a run state and at every wrap/turnaround. Inputs changing mid-segment have no effect until the next latch.
- States:
  - IDLE: freq_inst tracks center_freq every cycle.
  - RUN_UP and RUN_DOWN: freq_inst changes only on a tick.
- Mode detection: sweep_mode is registered; any change from the previous cycle is a restart, acted on the following cycle.
  - Restart to 00: go to IDLE.
  - Restart to 01 or 11: latch, freq_inst=f_lo, go to RUN_UP.
  - Restart to 10: latch, freq_inst=f_hi, go to RUN_DOWN.
  - A restart overrides a tick arriving in the same cycle.
- RUN_UP on tick:
  - If freq_inst+spd < f_hi: freq_inst += spd.
  - Else if mode 01: re-latch, freq_inst=new f_lo, pulse sweep_wrap.
  - Else (mode 11): freq_inst=f_hi, go to RUN_DOWN. No re-latch and no pulse.
- RUN_DOWN on tick:
  - If freq_inst > f_lo+spd: freq_inst -= spd.
  - Else if mode 10: re-latch, freq_inst=new f_hi, pulse sweep_wrap.
  - Else (mode 11): re-latch, freq_inst=new f_lo, pulse sweep_wrap, go to RUN_UP.
- Degenerate cases:
  - spd=0: freq_inst holds and there is no wrap.
  - f_lo==f_hi: freq_inst holds at that value and there are no wrap pulses.
  - In both cases the state persists and the sequencer re-evaluates at the next restart.
- freq_inst is always within [F_MIN, F_MAX].
- Handshake:
  - Any cycle in which freq_inst is written with a different value sets upd_valid.
  - upd_valid clears on upd_valid&&upd_ready, unless freq_inst changes in that same cycle, in which case it stays set.
  - Latest value wins: intermediate values may be skipped. The sweep never stalls on upd_ready.
- sweep_active is registered, high one cycle after entering RUN_UP/RUN_DOWN, and low one cycle after entering IDLE.

Test Plan:
1. Reset, then sweep_mode=00, center_freq=100000, upd_ready=1 -> freq_inst=100000 within 2 cycles; one upd_valid&&upd_ready beat per change; sweep_active=0.
2. TICK_CYCLES=10, center=100000, range=20000, speed=4000, mode 01 -> freq_inst sequence 90000, 94000, 98000, 102000, 106000, then 90000 on the 5th tick with a one-cycle sweep_wrap; sweep_active=1.
3. Same settings, mode 11 -> 90000…106000, 110000 (clamped turnaround), 106000…94000, then 90000 with sweep_wrap, then rising again.
4. center=2000, range=50000 in mode 01 -> f_lo=1000 (F_MIN clamp); center=990000 in mode 10 -> starts at 999999 (F_MAX clamp); freq_inst never leaves [1000, 999999].
5. upd_ready=0 for 3 ticks during a ramp -> upd_valid stays 1 and freq_inst shows the latest value; raise upd_ready -> a single handshake beat, upd_valid=0 next cycle.
6. Mode 01 mid-ramp: change range to 0 -> no effect until the wrap. Then switch mode to 10 mid-ramp -> next cycle freq_inst=f_hi in RUN_DOWN. Then assert rst_n=0 asynchronously -> outputs reach reset values immediately.
